// File: rtl/regfile_sb.sv
// Two-read/one-write register file with byte-enabled writes, write-to-read forwarding,
// optional registered reads and a per-register pending-write (busy) scoreboard.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned REG_READ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ra1,
  input  logic [ADDR_W-1:0]     ra2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic                  rd1_busy,
  output logic                  rd2_busy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam bit          ZeroEn   = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] fwd_data [2];
  logic [1:0]        fwd_busy;
  logic              wr_ok;

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign wr_ok = we && !(ZeroEn && wa == '0);

  // Read path: storage merged with the in-flight write; a write to the read address
  // retires the pending producer, so busy is suppressed in the same cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_data[p] = mem_q[ra[p]];
      fwd_busy[p] = busy_q[ra[p]];
      if (we && wa == ra[p]) begin
        fwd_busy[p] = 1'b0;
        for (int b = 0; b < NumBytes; b++) begin
          if (wbe[b]) fwd_data[p][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if (ZeroEn && ra[p] == '0) begin
        fwd_data[p] = '0;
        fwd_busy[p] = 1'b0;
      end
    end
  end

  // Flush first, then writeback clear, then issue set: a new producer always wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) busy_d = '0;
    if (we) busy_d[wa] = 1'b0;
    if (iss_valid && !(ZeroEn && iss_addr == '0)) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (wbe[b]) mem_q[wa][8*b +: 8] <= wd[8*b +: 8];
        end
      end
      busy_q <= busy_d;
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    always_ff @(posedge clk) begin
      if (rst) begin
        rd1      <= '0;
        rd2      <= '0;
        rd1_busy <= 1'b0;
        rd2_busy <= 1'b0;
      end else begin
        rd1      <= fwd_data[0];
        rd2      <= fwd_data[1];
        rd1_busy <= fwd_busy[0];
        rd2_busy <= fwd_busy[1];
      end
    end
  end else begin : g_comb_read
    assign rd1      = fwd_data[0];
    assign rd2      = fwd_data[1];
    assign rd1_busy = fwd_busy[0];
    assign rd2_busy = fwd_busy[1];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Drives a combinational-read and a registered-read instance with the same stimulus and
// checks both against a reference model through an expected-value queue.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst, we, iss_valid, flush;
  logic [5:0]  ra1, ra2, wa, iss_addr;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [31:0] rd1_c, rd2_c, rd1_r, rd2_r;
  logic        b1_c, b2_c, b1_r, b2_r;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_mem [64];
  logic [63:0] m_busy;
  logic [31:0] c_rd1, c_rd2;
  logic        c_b1, c_b2;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(6), .ZERO_REG(1), .REG_READ(0)) dut_c (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_c), .rd2(rd2_c),
    .rd1_busy(b1_c), .rd2_busy(b2_c), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(6), .ZERO_REG(1), .REG_READ(1)) dut_r (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_r), .rd2(rd2_r),
    .rd1_busy(b1_r), .rd2_busy(b2_r), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [5:0] a);
    logic [31:0] v;
    v = m_mem[a];
    if (we && wa == a)
      for (int b = 0; b < 4; b++) if (wbe[b]) v[8*b +: 8] = wd[8*b +: 8];
    if (a == 6'd0) v = '0;
    return v;
  endfunction

  function automatic logic ref_busy(input logic [5:0] a);
    if (a == 6'd0) return 1'b0;
    return m_busy[a] && !(we && wa == a);
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      if (we && wa != 6'd0)
        for (int b = 0; b < 4; b++) if (wbe[b]) m_mem[wa][8*b +: 8] = wd[8*b +: 8];
      if (flush) m_busy = '0;
      if (we) m_busy[wa] = 1'b0;
      if (iss_valid && iss_addr != 6'd0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  // One clock cycle: drive, check the combinational instance, push the expectation for the
  // registered instance, then pop and compare it after the edge.
  task automatic step(input logic r, input logic w, input logic [5:0] a_w,
                      input logic [31:0] d, input logic [3:0] be, input logic iv,
                      input logic [5:0] ia, input logic fl, input logic [5:0] a1,
                      input logic [5:0] a2);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; wa = a_w; wd = d; wbe = be;
    iss_valid = iv; iss_addr = ia; flush = fl; ra1 = a1; ra2 = a2;
    if (r) e = '0;
    else e = '{d1: ref_data(a1), d2: ref_data(a2), b1: ref_busy(a1), b2: ref_busy(a2)};
    exp_q.push_back(e);
    #1;
    c_rd1 = rd1_c; c_rd2 = rd2_c; c_b1 = b1_c; c_b2 = b2_c;
    if (!r) begin
      check("comb_rd1", rd1_c, e.d1);
      check("comb_rd2", rd2_c, e.d2);
      check("comb_b1", {31'd0, b1_c}, {31'd0, e.b1});
      check("comb_b2", {31'd0, b2_c}, {31'd0, e.b2});
    end
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("reg_rd1", rd1_r, e.d1);
    check("reg_rd2", rd2_r, e.d2);
    check("reg_b1", {31'd0, b1_r}, {31'd0, e.b1});
    check("reg_b2", {31'd0, b2_r}, {31'd0, e.b2});
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; wbe = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0; ra1 = '0; ra2 = '0;
    m_busy = '0;
    //   r  w  wa  wd            wbe   iv ia  fl ra1 ra2
    step(1, 0, 0,  32'h0,        4'h0, 0, 0,  0, 0,  0);

    // Reset clears contents and busy, ignoring the same-cycle write and issue
    step(0, 1, 5,  32'hA5A5A5A5, 4'hF, 0, 0,  0, 0,  0);
    step(0, 1, 9,  32'h5A5A5A5A, 4'hF, 1, 9,  0, 5,  9);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 5,  9);
    check("pre_rst_rd2", c_rd2, 32'h5A5A5A5A);
    check("pre_rst_b2", {31'd0, c_b2}, 32'd1);
    step(1, 1, 5,  32'hFFFFFFFF, 4'hF, 1, 9,  0, 5,  9);
    check("rst_reg_rd1", rd1_r, 32'h0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 5,  9);
    check("rst_rd1", c_rd1, 32'h0);
    check("rst_rd2", c_rd2, 32'h0);
    check("rst_b2", {31'd0, c_b2}, 32'd0);

    // Byte-enable merge
    step(0, 1, 3,  32'h11223344, 4'hF, 0, 0,  0, 0,  0);
    step(0, 1, 3,  32'hAABBCCDD, 4'h5, 0, 0,  0, 0,  0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 3,  3);
    check("be_merge_c", c_rd1, 32'h11BB33DD);
    check("be_merge_r", rd2_r, 32'h11BB33DD);

    // Same-cycle write forwarding on both read flavours
    step(0, 1, 7,  32'hDEADBEEF, 4'hF, 0, 0,  0, 7,  0);
    check("fwd_c", c_rd1, 32'hDEADBEEF);
    check("fwd_r", rd1_r, 32'hDEADBEEF);

    // Zero register ignores writes and issues
    step(0, 1, 0,  32'h00001234, 4'hF, 1, 0,  0, 0,  0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 0,  0);
    check("zero_rd1", c_rd1, 32'h0);
    check("zero_b1", {31'd0, c_b1}, 32'd0);

    // Scoreboard: issue, write+reissue keeps busy, plain write clears
    step(0, 0, 0,  32'h0,        4'h0, 1, 12, 0, 12, 0);
    check("iss_not_yet_r", {31'd0, b1_r}, 32'd0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 12, 0);
    check("iss_busy", {31'd0, c_b1}, 32'd1);
    step(0, 1, 12, 32'h0000C0DE, 4'hF, 1, 12, 0, 12, 0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 12, 0);
    check("reissue_busy", {31'd0, c_b1}, 32'd1);
    step(0, 1, 12, 32'h0000BEEF, 4'hF, 0, 0,  0, 0,  0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 12, 0);
    check("wb_clear", {31'd0, c_b1}, 32'd0);

    // Write with no byte enables still retires the producer
    step(0, 0, 0,  32'h0,        4'h0, 1, 20, 0, 0,  0);
    step(0, 1, 20, 32'hFFFFFFFF, 4'h0, 0, 0,  0, 0,  0);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 20, 0);
    check("be0_busy", {31'd0, c_b1}, 32'd0);
    check("be0_data", c_rd1, 32'h0);

    // Flush with a concurrent issue
    step(0, 1, 1,  32'h01010101, 4'hF, 1, 1,  0, 0,  0);
    step(0, 0, 0,  32'h0,        4'h0, 1, 2,  0, 0,  0);
    step(0, 0, 0,  32'h0,        4'h0, 1, 3,  0, 1,  2);
    step(0, 0, 0,  32'h0,        4'h0, 1, 2,  1, 1,  2);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 1,  2);
    check("flush_b1", {31'd0, c_b1}, 32'd0);
    check("flush_b2", {31'd0, c_b2}, 32'd1);
    check("flush_data1", c_rd1, 32'h01010101);
    step(0, 0, 0,  32'h0,        4'h0, 0, 0,  0, 3,  3);
    check("flush_b3", {31'd0, c_b1}, 32'd0);
    check("flush_data3", c_rd2, 32'h11BB33DD);

    // Busy forwarding on port 2
    step(0, 0, 0,  32'h0,        4'h0, 1, 4,  0, 0,  0);
    step(0, 1, 4,  32'hCAFEF00D, 4'hF, 0, 0,  0, 0,  4);
    check("bfwd_b2", {31'd0, c_b2}, 32'd0);
    check("bfwd_rd2", c_rd2, 32'hCAFEF00D);
    check("bfwd_rd2_r", rd2_r, 32'hCAFEF00D);

    // Sweep: write a pattern across many registers and read it back
    for (int i = 1; i < 64; i += 7) begin
      step(0, 1, 6'(i), 32'h1000_0000 + 32'(i * 3), 4'hF, 1, 6'(i + 1), 0, 6'(i), 6'(i + 1));
    end
    for (int i = 1; i < 64; i += 7) begin
      step(0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 6'(i), 6'(i + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
